pzcorebus_request_arbiter: RTL and testbench
============================================

Name: pzcorebus_request_arbiter

Overview:
- Shares one pzcorebus request channel (command + write data) between N requesters.
- Round-robin command arbitration; the write data channel is replayed in command-grant order.
- Holds the granted command stable until accepted, and never interleaves write-data bursts.
- Sits between initiator-side request ports and a single downstream slave port. Its output passes the team's request SVA checks (keep-until-acceptance, data count matches burst length).

Parameters:
- N, 4, number of requesters (2..16)
- CMD_WIDTH, 64, packed command width (command, id, address, length)
- DATA_WIDTH, 72, packed write data width (data + byte enable)
- LEN_WIDTH, 8, burst length width (beats, 1..2^LEN_WIDTH-1)
- DEPTH, 4, order FIFO depth (write commands granted but data not yet complete)

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_mcmd_valid  input  N  per-requester command valid
- o_scmd_accept  output  N  per-requester command accept
- i_mcmd  input  N*CMD_WIDTH  per-requester command
- i_mcmd_with_data  input  N  command carries write data
- i_mburst_length  input  N*LEN_WIDTH  write burst length in beats
- i_mdata_valid  input  N  per-requester data valid
- o_sdata_accept  output  N  per-requester data accept
- i_mdata  input  N*DATA_WIDTH  per-requester write data
- i_mdata_last  input  N  last beat flag
- o_mcmd_valid  output  1  downstream command valid
- i_scmd_accept  input  1  downstream command accept
- o_mcmd  output  CMD_WIDTH  downstream command
- o_mcmd_source  output  $clog2(N)  granted requester index
- o_mdata_valid  output  1  downstream data valid
- i_sdata_accept  input  1  downstream data accept
- o_mdata  output  DATA_WIDTH  downstream write data
- o_mdata_last  output  1  downstream last flag
- o_length_error  output  1  sticky burst length mismatch

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values:
  - all outputs 0;
  - round-robin pointer 0;
  - lock flag clear;
  - order FIFO empty;
  - beat counter 0.
- Eligibility: requester i is eligible when i_mcmd_valid[i] && !(i_mcmd_with_data[i] && fifo_full).
- Arbitration is combinational, zero latency.
  - If unlocked, pick the first eligible requester at or after the pointer (wrapping at N-1 to 0). Drive o_mcmd_valid=1, o_mcmd, o_mcmd_source from it.
  - o_scmd_accept[g]=i_scmd_accept for the granted index g only; all other bits are 0.
- Lock:
  - If o_mcmd_valid && !i_scmd_accept, register lock=1 and lock_index=g. While locked, the grant stays on lock_index regardless of other requesters or the FIFO state, so o_mcmd is stable until acceptance.
  - Lock clears on the accept cycle.
- Pointer update: on accept, pointer <= (g+1) mod N.
- Order FIFO:
  - On accept of a command with data, push {g, i_mburst_length[g]}.
  - Capacity DEPTH. Full masks only write commands; non-write commands are still granted.
- Data channel:
  - Data is forwarded only for the FIFO head; o_mdata_valid = !empty && i_mdata_valid[head].
  - o_sdata_accept[head]=i_sdata_accept; all other bits are 0.
  - Data of a command pushed in cycle t is forwardable from cycle t+1; no same-cycle bypass.
  - Requesters presenting data early wait (not accepted).
- Pop: on beat ack (o_mdata_valid && i_sdata_accept) with o_mdata_last=1, pop the head and reset the beat counter to 0. Otherwise a beat ack increments the counter.
- Simultaneous push and pop in one cycle is legal; count is unchanged. A push while full cannot occur because of masking.
- Reset mid-burst: FIFO, lock and counter are cleared immediately; partially transferred bursts are dropped.
- Without the length-check feature, o_mdata_last = i_mdata_last[head] and o_length_error is tied 0.

Optional Feature:
- Macro: PZCOREBUS_REQUEST_ARBITER_LENGTH_CHECK_EN.
- Defined:
  - o_mdata_last = (beat_count+1 == head.burst_length); the requester's last flag is ignored for popping.
  - o_length_error is set (sticky until reset) on any beat ack where i_mdata_last[head] != that value.
- Undefined: the counter is still used for pop bookkeeping; o_length_error=0.

Decomposition:
- pzcorebus_arbiter_pkg holds:
  - typedef pzcorebus_arbiter_order_entry {index, burst_length};
  - function calc_rr_grant(valid, pointer).
- Sub-module pzcorebus_request_arbiter_order_fifo: synchronous FIFO, DEPTH entries, with push/pop/full/empty and head output. Async reset to empty.

Test Plan:
- N=4, all requesters issue read commands continuously with i_scmd_accept=1 → grants cycle 0,1,2,3,0; one accept per cycle.
- Requester 2 holds a read; i_scmd_accept=0 for 3 cycles while requester 1 also raises valid → o_mcmd_source stays 2 and o_mcmd stays stable. On accept, next grant is 3 if valid, else 0, else 1 (round-robin from 3).
- Write from requester 0 (len 4), then write from requester 3 (len 2); requester 3 presents data first → requester 3 data is stalled until requester 0's 4 beats finish (last on beat 4); then 2 beats from requester 3.
- DEPTH=4: 4 write commands accepted, no data sent → 5th write masked, concurrent read from another requester still granted. One burst completing frees a slot; the write is granted the next cycle.
- Pop and push in the same cycle with the FIFO at 3 entries → count stays 3, entry order is preserved.
- Macro defined, len 4, requester asserts last on beat 3 → o_mdata_last on beat 4, o_length_error=1 from the cycle after beat 3 until reset. Reset mid-burst → all outputs 0, FIFO empty.

Source files
------------

// File: rtl/pzcorebus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// pzcorebus_arbiter_pkg
// Shared types and helpers for the pzcorebus request arbiter.
//   pzcorebus_arbiter_order_entry : one write-data ordering record
//                                   (requester index + burst length in beats)
//   calc_rr_grant(valid, pointer) : first set bit of valid at or after pointer,
//                                   wrapping at 15 back to 0
// Entry fields are sized for the largest supported configuration (16
// requesters, 16-bit burst length); users zero-extend into them and
// truncate back out.
// -----------------------------------------------------------------------------
package pzcorebus_arbiter_pkg;

    localparam int PZCOREBUS_ARBITER_MAX_N         = 16;
    localparam int PZCOREBUS_ARBITER_INDEX_WIDTH   = 4;
    localparam int PZCOREBUS_ARBITER_MAX_LEN_WIDTH = 16;

    typedef struct packed {
        logic [PZCOREBUS_ARBITER_INDEX_WIDTH-1:0]   index;
        logic [PZCOREBUS_ARBITER_MAX_LEN_WIDTH-1:0] burst_length;
    } pzcorebus_arbiter_order_entry;

    // The search always spans 16 slots. Requesters at or above N never
    // drive a valid bit, so wrapping at 15 gives the same winner as
    // wrapping at N-1. Slots are visited from furthest to nearest so that
    // the nearest valid slot is the one left in grant.
    function automatic logic [PZCOREBUS_ARBITER_INDEX_WIDTH-1:0] calc_rr_grant(
        input logic [PZCOREBUS_ARBITER_MAX_N-1:0]       valid,
        input logic [PZCOREBUS_ARBITER_INDEX_WIDTH-1:0] pointer
    );
        logic [PZCOREBUS_ARBITER_INDEX_WIDTH-1:0] grant;
        logic [PZCOREBUS_ARBITER_INDEX_WIDTH-1:0] slot;
        grant = pointer;
        for (int i = PZCOREBUS_ARBITER_MAX_N - 1; i >= 0; i--) begin
            slot = pointer + PZCOREBUS_ARBITER_INDEX_WIDTH'(i);
            if (valid[slot]) begin
                grant = slot;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/pzcorebus_request_arbiter_order_fifo.sv
// -----------------------------------------------------------------------------
// pzcorebus_request_arbiter_order_fifo
// Synchronous FIFO of write-data ordering records. The head is read
// combinationally, so an entry pushed in cycle t is visible from t+1.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset (-> empty)
//   i_push, i_push_entry  write one record (caller never pushes when full)
//   i_pop                 drop the head (caller never pops when empty)
//   o_full, o_empty       occupancy flags
//   o_head                oldest record
// -----------------------------------------------------------------------------
module pzcorebus_request_arbiter_order_fifo
    import pzcorebus_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  pzcorebus_arbiter_order_entry i_push_entry,
    input  logic                         i_pop,
    output logic                         o_full,
    output logic                         o_empty,
    output pzcorebus_arbiter_order_entry o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    pzcorebus_arbiter_order_entry mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    // Storage needs no reset: only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem[wr_ptr_reg] <= i_push_entry;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (i_push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (i_pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        if (i_push && !i_pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!i_push && i_pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign o_full  = (count_reg == CNT_W'(DEPTH));
    assign o_empty = (count_reg == '0);
    assign o_head  = mem[rd_ptr_reg];

endmodule

// File: rtl/pzcorebus_request_arbiter.sv
// -----------------------------------------------------------------------------
// pzcorebus_request_arbiter
// Shares one pzcorebus request channel between N requesters. Commands are
// arbitrated round-robin with zero latency; a granted command that is not
// accepted locks the grant until acceptance. Each accepted write command
// records {requester, burst length} in an order FIFO, and write data is
// forwarded only from the FIFO head, so bursts never interleave and follow
// command-grant order.
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_mcmd_valid/o_scmd_accept/i_mcmd   per-requester command handshake
//   i_mcmd_with_data, i_mburst_length   write flag and burst length (beats)
//   i_mdata_valid/o_sdata_accept/i_mdata/i_mdata_last  per-requester data
//   o_mcmd_valid/i_scmd_accept/o_mcmd/o_mcmd_source    downstream command
//   o_mdata_valid/i_sdata_accept/o_mdata/o_mdata_last  downstream data
//   o_length_error                      sticky burst length mismatch
// Build option:
//   PZCOREBUS_REQUEST_ARBITER_LENGTH_CHECK_EN - generate the downstream last
//   flag from the recorded burst length and flag requesters whose last flag
//   disagrees. Undefined: the requester's last flag is passed through and
//   o_length_error is 0.
// -----------------------------------------------------------------------------
module pzcorebus_request_arbiter
    import pzcorebus_arbiter_pkg::*;
#(
    parameter int N          = 4,
    parameter int CMD_WIDTH  = 64,
    parameter int DATA_WIDTH = 72,
    parameter int LEN_WIDTH  = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N-1:0]            i_mcmd_valid,
    output logic [N-1:0]            o_scmd_accept,
    input  logic [N*CMD_WIDTH-1:0]  i_mcmd,
    input  logic [N-1:0]            i_mcmd_with_data,
    input  logic [N*LEN_WIDTH-1:0]  i_mburst_length,
    input  logic [N-1:0]            i_mdata_valid,
    output logic [N-1:0]            o_sdata_accept,
    input  logic [N*DATA_WIDTH-1:0] i_mdata,
    input  logic [N-1:0]            i_mdata_last,
    output logic                    o_mcmd_valid,
    input  logic                    i_scmd_accept,
    output logic [CMD_WIDTH-1:0]    o_mcmd,
    output logic [$clog2(N)-1:0]    o_mcmd_source,
    output logic                    o_mdata_valid,
    input  logic                    i_sdata_accept,
    output logic [DATA_WIDTH-1:0]   o_mdata,
    output logic                    o_mdata_last,
    output logic                    o_length_error
);

    localparam int IDX_W = $clog2(N);

    logic [N-1:0]                         eligible;
    logic [PZCOREBUS_ARBITER_INDEX_WIDTH-1:0] rr_grant;
    logic [IDX_W-1:0]                     grant;
    logic                                 cmd_valid;
    logic                                 cmd_ack;
    logic                                 push;
    logic                                 lock_reg, lock_next;
    logic [IDX_W-1:0]                     lock_index_reg, lock_index_next;
    logic [IDX_W-1:0]                     ptr_reg, ptr_next;

    pzcorebus_arbiter_order_entry         push_entry;
    pzcorebus_arbiter_order_entry         head_entry;
    logic                                 fifo_full;
    logic                                 fifo_empty;
    logic [IDX_W-1:0]                     head_index;
    logic [LEN_WIDTH-1:0]                 head_length;
    logic                                 data_valid;
    logic                                 data_last;
    logic                                 beat_ack;
    logic                                 pop;
    logic [LEN_WIDTH-1:0]                 beat_count_reg, beat_count_next;

    // ---------------------------------------------------------------- command
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        // A full order FIFO only holds back writes; reads still pass.
        assign eligible[gi]       = i_mcmd_valid[gi] && !(i_mcmd_with_data[gi] && fifo_full);
        assign o_scmd_accept[gi]  = cmd_ack && (grant == IDX_W'(gi));
        assign o_sdata_accept[gi] = !fifo_empty && i_sdata_accept && (head_index == IDX_W'(gi));
    end

    assign rr_grant = calc_rr_grant(PZCOREBUS_ARBITER_MAX_N'(eligible),
                                    PZCOREBUS_ARBITER_INDEX_WIDTH'(ptr_reg));

    // A locked grant ignores the FIFO state: a write only gets locked after
    // winning with room available, and the FIFO cannot fill while it waits.
    // Reset forces the command side idle even if requesters keep valid high.
    assign grant     = lock_reg ? lock_index_reg : IDX_W'(rr_grant);
    assign cmd_valid = i_rst_n && (lock_reg ? i_mcmd_valid[lock_index_reg] : |eligible);
    assign cmd_ack   = cmd_valid && i_scmd_accept;
    assign push      = cmd_ack && i_mcmd_with_data[grant];

    assign o_mcmd_valid  = cmd_valid;
    assign o_mcmd_source = cmd_valid ? grant : '0;
    assign o_mcmd        = cmd_valid ? i_mcmd[grant*CMD_WIDTH +: CMD_WIDTH] : '0;

    always_comb begin
        lock_next       = cmd_valid && !i_scmd_accept;
        lock_index_next = grant;
        ptr_next        = ptr_reg;
        if (cmd_ack) begin
            ptr_next = (grant == IDX_W'(N - 1)) ? '0 : grant + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------ order FIFO
    always_comb begin
        push_entry              = '0;
        push_entry.index        = PZCOREBUS_ARBITER_INDEX_WIDTH'(grant);
        push_entry.burst_length = PZCOREBUS_ARBITER_MAX_LEN_WIDTH'(i_mburst_length[grant*LEN_WIDTH +: LEN_WIDTH]);
    end

    pzcorebus_request_arbiter_order_fifo #(
        .DEPTH (DEPTH)
    ) u_order_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (push),
        .i_push_entry (push_entry),
        .i_pop        (pop),
        .o_full       (fifo_full),
        .o_empty      (fifo_empty),
        .o_head       (head_entry)
    );

    assign head_index  = IDX_W'(head_entry.index);
    assign head_length = LEN_WIDTH'(head_entry.burst_length);

    // ------------------------------------------------------------------ data
    assign data_valid    = !fifo_empty && i_mdata_valid[head_index];
    assign beat_ack      = data_valid && i_sdata_accept;
    assign pop           = beat_ack && data_last;
    assign o_mdata_valid = data_valid;
    assign o_mdata       = fifo_empty ? '0 : i_mdata[head_index*DATA_WIDTH +: DATA_WIDTH];
    assign o_mdata_last  = !fifo_empty && data_last;

    always_comb begin
        beat_count_next = beat_count_reg;
        if (pop) begin
            beat_count_next = '0;
        end else if (beat_ack) begin
            beat_count_next = beat_count_reg + LEN_WIDTH'(1);
        end
    end

`ifdef PZCOREBUS_REQUEST_ARBITER_LENGTH_CHECK_EN
    logic calc_last;
    logic length_error_reg;

    assign calc_last = (({1'b0, beat_count_reg} + {{LEN_WIDTH{1'b0}}, 1'b1}) == {1'b0, head_length});
    assign data_last = calc_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            length_error_reg <= 1'b0;
        end else if (beat_ack && (i_mdata_last[head_index] != calc_last)) begin
            length_error_reg <= 1'b1;
        end
    end

    assign o_length_error = length_error_reg;
`else
    // The recorded length is only consumed by the length checker.
    logic unused_head_length;

    assign unused_head_length = ^head_length;
    assign data_last          = i_mdata_last[head_index];
    assign o_length_error     = 1'b0;
`endif

    // ------------------------------------------------------------- registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_reg       <= 1'b0;
            lock_index_reg <= '0;
            ptr_reg        <= '0;
            beat_count_reg <= '0;
        end else begin
            lock_reg       <= lock_next;
            lock_index_reg <= lock_index_next;
            ptr_reg        <= ptr_next;
            beat_count_reg <= beat_count_next;
        end
    end

endmodule

// File: tb/tb_pzcorebus_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pzcorebus_request_arbiter
// Directed bench for pzcorebus_request_arbiter (N=4, DEPTH=4): a vector
// table for round-robin and lock behaviour, then hand-written sequences for
// write ordering, FIFO full masking, push/pop at 3 entries, the burst length
// check and reset in the middle of a burst.
// -----------------------------------------------------------------------------
module tb_pzcorebus_request_arbiter;

    localparam int N          = 4;
    localparam int CMD_WIDTH  = 64;
    localparam int DATA_WIDTH = 72;
    localparam int LEN_WIDTH  = 8;
    localparam int DEPTH      = 4;

    logic                    i_clk = 1'b0;
    logic                    i_rst_n;
    logic [N-1:0]            i_mcmd_valid;
    logic [N-1:0]            o_scmd_accept;
    logic [N*CMD_WIDTH-1:0]  i_mcmd;
    logic [N-1:0]            i_mcmd_with_data;
    logic [N*LEN_WIDTH-1:0]  i_mburst_length;
    logic [N-1:0]            i_mdata_valid;
    logic [N-1:0]            o_sdata_accept;
    logic [N*DATA_WIDTH-1:0] i_mdata;
    logic [N-1:0]            i_mdata_last;
    logic                    o_mcmd_valid;
    logic                    i_scmd_accept;
    logic [CMD_WIDTH-1:0]    o_mcmd;
    logic [1:0]              o_mcmd_source;
    logic                    o_mdata_valid;
    logic                    i_sdata_accept;
    logic [DATA_WIDTH-1:0]   o_mdata;
    logic                    o_mdata_last;
    logic                    o_length_error;

    pzcorebus_request_arbiter #(
        .N          (N),
        .CMD_WIDTH  (CMD_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_mcmd_valid     (i_mcmd_valid),
        .o_scmd_accept    (o_scmd_accept),
        .i_mcmd           (i_mcmd),
        .i_mcmd_with_data (i_mcmd_with_data),
        .i_mburst_length  (i_mburst_length),
        .i_mdata_valid    (i_mdata_valid),
        .o_sdata_accept   (o_sdata_accept),
        .i_mdata          (i_mdata),
        .i_mdata_last     (i_mdata_last),
        .o_mcmd_valid     (o_mcmd_valid),
        .i_scmd_accept    (i_scmd_accept),
        .o_mcmd           (o_mcmd),
        .o_mcmd_source    (o_mcmd_source),
        .o_mdata_valid    (o_mdata_valid),
        .i_sdata_accept   (i_sdata_accept),
        .o_mdata          (o_mdata),
        .o_mdata_last     (o_mdata_last),
        .o_length_error   (o_length_error)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] valid;
        logic       scmd_acc;
        logic       exp_valid;
        int         exp_src;
        logic [3:0] exp_acc;
    } rr_vec_t;

    rr_vec_t vecs [13];

    function automatic logic [CMD_WIDTH-1:0] cmd_of(input int r);
        return {32'hC0DE_0000, 32'(r) * 32'h1111_1111};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] data_of(input int r, input int beat);
        return {8'(r + 1), 32'hDA7A_0000, 32'(beat)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input logic v, input int src, input logic [3:0] acc);
        check({tag, ".mcmd_valid"}, 128'(o_mcmd_valid), 128'(v));
        check({tag, ".mcmd_source"}, 128'(o_mcmd_source), v ? 128'(src) : 128'(0));
        check({tag, ".mcmd"}, 128'(o_mcmd), v ? 128'(cmd_of(src)) : 128'(0));
        check({tag, ".scmd_accept"}, 128'(o_scmd_accept), 128'(acc));
    endtask

    task automatic check_data(input string tag, input logic v, input int src, input int beat,
                              input logic last, input logic [3:0] acc);
        check({tag, ".mdata_valid"}, 128'(o_mdata_valid), 128'(v));
        if (v) begin
            check({tag, ".mdata"}, 128'(o_mdata), 128'(data_of(src, beat)));
            check({tag, ".mdata_last"}, 128'(o_mdata_last), 128'(last));
        end
        check({tag, ".sdata_accept"}, 128'(o_sdata_accept), 128'(acc));
    endtask

    task automatic advance();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        i_mcmd_valid     = '0;
        i_mcmd_with_data = '0;
        i_mburst_length  = '0;
        i_mdata_valid    = '0;
        i_mdata_last     = '0;
        i_scmd_accept    = 1'b1;
        i_sdata_accept   = 1'b1;
        for (int r = 0; r < N; r++) begin
            i_mdata[r*DATA_WIDTH +: DATA_WIDTH] = data_of(r, 0);
        end
    endtask

    task automatic set_write(input int r, input int len);
        i_mcmd_valid     = 4'b0001 << r;
        i_mcmd_with_data = 4'b0001 << r;
        i_mburst_length[r*LEN_WIDTH +: LEN_WIDTH] = 8'(len);
    endtask

    task automatic set_beat(input int r, input int beat, input logic last);
        i_mdata[r*DATA_WIDTH +: DATA_WIDTH] = data_of(r, beat);
        i_mdata_last[r] = last;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Round-robin and lock vectors, starting from pointer 0.
        vecs[0]  = '{4'b1111, 1'b1, 1'b1, 0, 4'b0001};
        vecs[1]  = '{4'b1111, 1'b1, 1'b1, 1, 4'b0010};
        vecs[2]  = '{4'b1111, 1'b1, 1'b1, 2, 4'b0100};
        vecs[3]  = '{4'b1111, 1'b1, 1'b1, 3, 4'b1000};
        vecs[4]  = '{4'b1111, 1'b1, 1'b1, 0, 4'b0001};
        vecs[5]  = '{4'b0100, 1'b1, 1'b1, 2, 4'b0100};  // pointer -> 3
        vecs[6]  = '{4'b0100, 1'b0, 1'b1, 2, 4'b0000};  // stall, lock on 2
        vecs[7]  = '{4'b0110, 1'b0, 1'b1, 2, 4'b0000};  // unlocked would pick 1
        vecs[8]  = '{4'b1110, 1'b0, 1'b1, 2, 4'b0000};  // unlocked would pick 3
        vecs[9]  = '{4'b1110, 1'b1, 1'b1, 2, 4'b0100};  // accept, pointer -> 3
        vecs[10] = '{4'b1011, 1'b1, 1'b1, 3, 4'b1000};
        vecs[11] = '{4'b0011, 1'b1, 1'b1, 0, 4'b0001};
        vecs[12] = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000};

        for (int r = 0; r < N; r++) begin
            i_mcmd[r*CMD_WIDTH +: CMD_WIDTH] = cmd_of(r);
        end
        clear_inputs();
        i_rst_n = 1'b0;

        // Reset state.
        settle();
        check_cmd("reset", 1'b0, 0, 4'b0000);
        check_data("reset", 1'b0, 0, 0, 1'b0, 4'b0000);
        check("reset.mdata_last", 128'(o_mdata_last), 128'(0));
        check("reset.length_error", 128'(o_length_error), 128'(0));
        i_mcmd_valid = 4'b1111;
        #1;
        check_cmd("reset_valid_held", 1'b0, 0, 4'b0000);
        $display("reset: outputs idle with requesters valid");
        advance();
        i_rst_n = 1'b1;

        // Table: round-robin and lock.
        for (int i = 0; i < 13; i++) begin
            i_mcmd_valid  = vecs[i].valid;
            i_scmd_accept = vecs[i].scmd_acc;
            settle();
            check_cmd($sformatf("rr[%0d]", i), vecs[i].exp_valid, vecs[i].exp_src, vecs[i].exp_acc);
            $display("rr[%0d]: valid=%b accept=%b -> source=%0d scmd_accept=%b",
                     i, vecs[i].valid, vecs[i].scmd_acc, o_mcmd_source, o_scmd_accept);
            advance();
        end
        clear_inputs();

        // Write ordering: req0 len 4, then req3 len 2 with req3 data early.
        set_write(0, 4);
        i_mdata_valid = 4'b0001;  // no same-cycle bypass
        settle();
        check_cmd("wr_cmd0", 1'b1, 0, 4'b0001);
        check_data("wr_cmd0", 1'b0, 0, 0, 1'b0, 4'b0000);
        $display("order: write cmd from requester 0 len 4");
        advance();
        clear_inputs();
        set_write(3, 2);
        i_mdata_valid = 4'b1000;
        settle();
        check_cmd("wr_cmd3", 1'b1, 3, 4'b1000);
        check_data("wr_cmd3", 1'b0, 0, 0, 1'b0, 4'b0001);
        $display("order: write cmd from requester 3 len 2, requester 3 data stalled");
        advance();
        clear_inputs();
        i_mdata_valid = 4'b1001;
        set_beat(3, 0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            set_beat(0, b, b == 3);
            settle();
            check_data($sformatf("wr0_beat%0d", b), 1'b1, 0, b, b == 3, 4'b0001);
            $display("order: beat %0d from requester 0 last=%b", b, o_mdata_last);
            advance();
        end
        i_mdata_valid = 4'b1000;
        for (int b = 0; b < 2; b++) begin
            set_beat(3, b, b == 1);
            settle();
            check_data($sformatf("wr3_beat%0d", b), 1'b1, 3, b, b == 1, 4'b1000);
            $display("order: beat %0d from requester 3 last=%b", b, o_mdata_last);
            advance();
        end
        i_mdata_valid = 4'b1111;
        settle();
        check_data("wr_drained", 1'b0, 0, 0, 1'b0, 4'b0000);
        advance();
        clear_inputs();

        // FIFO full: four len-1 writes (pointer is 0 here).
        for (int r = 0; r < 4; r++) begin
            clear_inputs();
            set_write(r, 1);
            settle();
            check_cmd($sformatf("fill%0d", r), 1'b1, r, 4'b0001 << r);
            $display("full: write %0d from requester %0d", r, r);
            advance();
        end
        clear_inputs();
        set_write(0, 1);
        i_mcmd_valid = 4'b0011;  // req0 write masked, req1 read granted
        settle();
        check_cmd("full_read_passes", 1'b1, 1, 4'b0010);
        $display("full: write masked, read from requester 1 granted");
        advance();
        i_mcmd_valid = 4'b0001;
        i_mdata_valid = 4'b0001;
        set_beat(0, 0, 1'b1);
        settle();
        check_cmd("full_still_masked", 1'b0, 0, 4'b0000);
        check_data("full_pop0", 1'b1, 0, 0, 1'b1, 4'b0001);
        $display("full: burst 0 completes, write still masked this cycle");
        advance();
        i_mdata_valid = 4'b0000;
        settle();
        check_cmd("full_slot_freed", 1'b1, 0, 4'b0001);
        $display("full: freed slot, write from requester 0 granted");
        advance();
        clear_inputs();

        // FIFO holds 1,2,3,0. Pop one, then pop and push together at 3.
        i_mdata_valid = 4'b0010;
        set_beat(1, 0, 1'b1);
        settle();
        check_data("pop1", 1'b1, 1, 0, 1'b1, 4'b0010);
        advance();
        clear_inputs();
        i_mdata_valid = 4'b0100;
        set_beat(2, 0, 1'b1);
        set_write(1, 1);
        settle();
        check_cmd("pushpop_cmd", 1'b1, 1, 4'b0010);
        check_data("pushpop_data", 1'b1, 2, 0, 1'b1, 4'b0100);
        $display("pushpop: pop requester 2 and push requester 1 together");
        advance();
        clear_inputs();
        // Count must be 3 (not full): a write from requester 2 is granted.
        set_write(2, 1);
        i_mdata_valid = 4'b1111;
        i_mdata_last  = 4'b1111;
        settle();
        check_cmd("pushpop_not_full", 1'b1, 2, 4'b0100);
        check_data("drain3", 1'b1, 3, 0, 1'b1, 4'b1000);
        advance();
        i_mcmd_valid = '0;
        i_mcmd_with_data = '0;
        settle();
        check_data("drain0", 1'b1, 0, 0, 1'b1, 4'b0001);
        advance();
        settle();
        check_data("drain1", 1'b1, 1, 0, 1'b1, 4'b0010);
        advance();
        settle();
        check_data("drain2", 1'b1, 2, 0, 1'b1, 4'b0100);
        advance();
        settle();
        check_data("drain_empty", 1'b0, 0, 0, 1'b0, 4'b0000);
        $display("pushpop: drained in order 3,0,1,2");
        advance();
        clear_inputs();

        // Length check: requester 2, len 4, last flag on beat 3 (pointer is 3).
        set_write(2, 4);
        settle();
        check_cmd("len_cmd", 1'b1, 2, 4'b0100);
        advance();
        clear_inputs();
        i_mdata_valid = 4'b0100;
`ifdef PZCOREBUS_REQUEST_ARBITER_LENGTH_CHECK_EN
        for (int b = 0; b < 4; b++) begin
            set_beat(2, b, b == 2);
            settle();
            check_data($sformatf("len_beat%0d", b), 1'b1, 2, b, b == 3, 4'b0100);
            check($sformatf("len_error%0d", b), 128'(o_length_error), 128'(b == 3));
            $display("len: beat %0d last=%b length_error=%b", b, o_mdata_last, o_length_error);
            advance();
        end
        settle();
        check_data("len_done", 1'b0, 0, 0, 1'b0, 4'b0000);
        check("len_error_sticky", 128'(o_length_error), 128'(1));
`else
        for (int b = 0; b < 3; b++) begin
            set_beat(2, b, b == 2);
            settle();
            check_data($sformatf("len_beat%0d", b), 1'b1, 2, b, b == 2, 4'b0100);
            check($sformatf("len_error%0d", b), 128'(o_length_error), 128'(0));
            $display("len: beat %0d last=%b length_error=%b", b, o_mdata_last, o_length_error);
            advance();
        end
        settle();
        check_data("len_done", 1'b0, 0, 0, 1'b0, 4'b0000);
        check("len_error_off", 128'(o_length_error), 128'(0));
`endif
        advance();
        clear_inputs();

        // Reset mid-burst: requester 1 len 4 (pointer is 3), two beats, reset.
        set_write(1, 4);
        settle();
        check_cmd("rst_cmd", 1'b1, 1, 4'b0010);
        advance();
        clear_inputs();
        i_mdata_valid = 4'b0010;
        for (int b = 0; b < 2; b++) begin
            set_beat(1, b, 1'b0);
            settle();
            check_data($sformatf("rst_beat%0d", b), 1'b1, 1, b, 1'b0, 4'b0010);
            advance();
        end
        i_mcmd_valid = 4'b1111;
        i_rst_n = 1'b0;
        #1;
        check_cmd("midrst", 1'b0, 0, 4'b0000);
        check_data("midrst", 1'b0, 0, 0, 1'b0, 4'b0000);
        check("midrst.mdata", 128'(o_mdata), 128'(0));
        check("midrst.mdata_last", 128'(o_mdata_last), 128'(0));
        check("midrst.length_error", 128'(o_length_error), 128'(0));
        $display("midrst: reset asserted during burst, outputs idle");
        advance();
        i_rst_n = 1'b1;
        settle();
        check_cmd("after_rst", 1'b1, 0, 4'b0001);
        check_data("after_rst", 1'b0, 0, 0, 1'b0, 4'b0000);
        $display("midrst: after reset pointer 0, order FIFO empty");
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
